// File: rtl/inst_rom_ldr_pkg.sv
// Shared constants and types for the instruction ROM and its byte-stream loader.
package inst_rom_ldr_pkg;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;

  localparam logic [31:0]     ZERO_WORD = 32'h0000_0000;
  localparam logic [ADDR_W:0] LEN_MAX   = (ADDR_W+1)'(DEPTH);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } ldr_state_t;
endpackage

// File: rtl/inst_rom_ldr_if.sv
// Fetch port (core side) and loader byte stream grouped into one bundle.
interface inst_rom_ldr_if;
  import inst_rom_ldr_pkg::*;

  logic              ce_i;
  logic [31:0]       addr_i;
  logic [31:0]       inst_o;
  logic              ld_start_i;
  logic [ADDR_W:0]   ld_len_i;
  logic [7:0]        ld_data_i;
  logic              ld_valid_i;
  logic              ld_ready_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;

  modport slave (
    input  ce_i, addr_i, ld_start_i, ld_len_i, ld_data_i, ld_valid_i,
    output inst_o, ld_ready_o, busy_o, done_o, err_o
  );

  modport master (
    output ce_i, addr_i, ld_start_i, ld_len_i, ld_data_i, ld_valid_i,
    input  inst_o, ld_ready_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/inst_rom_ldr_byte_word_pack.sv
// Packs big-endian bytes into 32-bit words; the 4th byte bypasses the register
// so the completed word is available in the same cycle it is accepted.
module inst_rom_ldr_byte_word_pack (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_byte_vld,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_vld
);
  logic [1:0]  r_bcnt;
  logic [23:0] r_asm;

  always_ff @(posedge clk) begin
    if (!rst || i_clr) begin
      r_bcnt <= 2'd0;
      r_asm  <= 24'd0;
    end else if (i_byte_vld) begin
      r_bcnt <= r_bcnt + 2'd1;
      case (r_bcnt)
        2'd0:    r_asm[23:16] <= i_byte;
        2'd1:    r_asm[15:8]  <= i_byte;
        2'd2:    r_asm[7:0]   <= i_byte;
        default: ;
      endcase
    end
  end

  assign o_word     = {r_asm, i_byte};
  assign o_word_vld = i_byte_vld && !i_clr && (r_bcnt == 2'd3);
endmodule

// File: rtl/inst_rom_ldr.sv
// Instruction memory with combinational fetch port and a byte-stream loader
// that holds the core (busy_o) while a program image is written from word 0.
module inst_rom_ldr
  import inst_rom_ldr_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  inst_rom_ldr_if.slave  bus
);
  ldr_state_t        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W:0]   r_len;
  logic              r_done, r_err;
  logic [31:0]       r_mem [DEPTH];

  logic        w_start_ok, w_start_zero, w_start_big;
  logic        w_byte_acc, w_wr, w_last;
  logic        w_done_nxt;
  logic [31:0] w_word;

  assign w_start_zero = bus.ld_start_i && (bus.ld_len_i == '0);
  assign w_start_big  = bus.ld_start_i && (bus.ld_len_i > LEN_MAX);
  assign w_start_ok   = bus.ld_start_i && !w_start_zero && !w_start_big;

  // A start in the same cycle wins over the byte, so that byte is dropped.
  assign w_byte_acc = rst && !bus.ld_start_i && bus.ld_valid_i && (r_state == ST_LOAD);

  inst_rom_ldr_byte_word_pack u_pack (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (bus.ld_start_i),
    .i_byte_vld (w_byte_acc),
    .i_byte     (bus.ld_data_i),
    .o_word     (w_word),
    .o_word_vld (w_wr)
  );

  assign w_last = w_wr && ({1'b0, r_wptr} == (r_len - 1'b1));

  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) w_state_nxt = ST_LOAD;
        w_done_nxt = w_start_zero;
      end
      ST_LOAD: begin
        if (bus.ld_start_i) begin
          w_state_nxt = w_start_ok ? ST_LOAD : ST_IDLE;
          w_done_nxt  = w_start_zero;
        end else if (w_last) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr <= '0;
      r_len  <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      if (w_start_big)                    r_err <= 1'b1;
      else if (w_start_ok || w_start_zero) r_err <= 1'b0;
      if (w_start_ok) r_len <= bus.ld_len_i;
      if (bus.ld_start_i) r_wptr <= '0;
      else if (w_wr)      r_wptr <= r_wptr + 1'b1;
    end
  end

  // Contents survive reset so a half-finished load keeps its completed words.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= w_word;
  end

  assign bus.ld_ready_o = (r_state == ST_LOAD);
  assign bus.busy_o     = (r_state == ST_LOAD);
  assign bus.done_o     = r_done;
  assign bus.err_o      = r_err;

  always_comb begin
    bus.inst_o = ZERO_WORD;
    if (rst && bus.ce_i && !bus.busy_o && (bus.addr_i[31:ADDR_W+2] == '0))
      bus.inst_o = r_mem[bus.addr_i[ADDR_W+1:2]];
  end
endmodule

// File: tb/tb_inst_rom_ldr.sv
// Directed + randomized bench for inst_rom_ldr with a word-level memory model.
module tb_inst_rom_ldr;
  import inst_rom_ldr_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  inst_rom_ldr_if bus ();
  inst_rom_ldr dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;
  logic [31:0] ref_mem [int];
  logic [7:0]  bq [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic fetch_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    bus.ce_i = 1'b1; bus.addr_i = addr; #1;
    chk(tag, bus.inst_o, exp);
  endtask

  task automatic do_start(input int len);
    bus.ld_start_i = 1'b1; bus.ld_len_i = (ADDR_W+1)'(len);
    step();
    bus.ld_start_i = 1'b0;
  endtask

  // Sends the first nb bytes of bq; optional random idle gaps probe busy/fetch masking.
  task automatic send_q(input bit gaps, input int nb);
    for (int i = 0; i < nb; i++) begin
      if (gaps) begin
        int g = $urandom_range(0, 2);
        for (int j = 0; j < g; j++) begin
          bus.ld_valid_i = 1'b0;
          bus.ce_i = 1'b1; bus.addr_i = {20'd0, 10'($urandom), 2'b00}; #1;
          chk("busy_gap", 32'(bus.busy_o), 32'd1);
          chk("inst_masked", bus.inst_o, 32'd0);
          step();
        end
      end
      bus.ld_valid_i = 1'b1; bus.ld_data_i = bq[i];
      chk("ready", 32'(bus.ld_ready_o), 32'd1);
      step();
    end
    bus.ld_valid_i = 1'b0;
  endtask

  task automatic commit_q(input int nwords);
    for (int i = 0; i < nwords; i++)
      ref_mem[i] = {bq[4*i], bq[4*i+1], bq[4*i+2], bq[4*i+3]};
  endtask

  task automatic chk_done(input string tag);
    chk({tag, "_done"}, 32'(bus.done_o), 32'd1);
    chk({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
    chk({tag, "_rdy"}, 32'(bus.ld_ready_o), 32'd0);
    step();
    chk({tag, "_done_end"}, 32'(bus.done_o), 32'd0);
  endtask

  task automatic rand_q(input int nwords);
    bq = {};
    for (int i = 0; i < 4*nwords; i++) bq.push_back(8'($urandom));
  endtask

  initial begin
    bus.ce_i = 1'b0; bus.addr_i = '0; bus.ld_start_i = 1'b0; bus.ld_len_i = '0;
    bus.ld_data_i = '0; bus.ld_valid_i = 1'b0;

    // 1. reset
    step(); step();
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_rdy", 32'(bus.ld_ready_o), 32'd0);
    chk("rst_done", 32'(bus.done_o), 32'd0);
    chk("rst_err", 32'(bus.err_o), 32'd0);
    fetch_chk("rst_inst0", 32'd0, 32'd0);
    fetch_chk("rst_instr", {20'd0, 10'($urandom), 2'b00}, 32'd0);
    rst = 1'b1;
    step();

    // 2. two-word load
    do_start(2);
    chk("t2_busy", 32'(bus.busy_o), 32'd1);
    bq = '{8'h3C, 8'h01, 8'h00, 8'h10, 8'h34, 8'h21, 8'h00, 8'h20};
    send_q(1'b0, 8);
    chk_done("t2");
    commit_q(2);
    fetch_chk("t2_w0", 32'd0, 32'h3C01_0010);
    fetch_chk("t2_w1", 32'd4, 32'h3421_0020);
    fetch_chk("t2_w1b", 32'd6, ref_mem[1]);
    bus.ce_i = 1'b0; #1;
    chk("t2_ce0", bus.inst_o, 32'd0);

    // 3. oversize length rejected
    do_start(DEPTH + 1);
    chk("t3_err", 32'(bus.err_o), 32'd1);
    chk("t3_rdy", 32'(bus.ld_ready_o), 32'd0);
    chk("t3_busy", 32'(bus.busy_o), 32'd0);
    step();
    chk("t3_err_sticky", 32'(bus.err_o), 32'd1);
    fetch_chk("t3_w0", 32'd0, ref_mem[0]);
    fetch_chk("t3_w1", 32'd4, ref_mem[1]);
    do_start(1);
    chk("t3_err_clr", 32'(bus.err_o), 32'd0);
    rand_q(1);
    send_q(1'b0, 4);
    chk_done("t3");
    commit_q(1);
    fetch_chk("t3_new_w0", 32'd0, ref_mem[0]);

    // 4. restart discards partial word; start beats a same-cycle byte
    do_start(1);
    bq = '{8'h11, 8'h22};
    send_q(1'b0, 2);
    bus.ld_valid_i = 1'b1; bus.ld_data_i = 8'hEE;
    do_start(1);
    bus.ld_valid_i = 1'b0;
    chk("t4_busy", 32'(bus.busy_o), 32'd1);
    bq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_q(1'b0, 4);
    chk_done("t4");
    commit_q(1);
    fetch_chk("t4_w0", 32'd0, 32'hAABB_CCDD);

    // 5. len=4 with random valid gaps, then random loads
    do_start(4);
    rand_q(4);
    send_q(1'b1, 16);
    chk_done("t5");
    commit_q(4);
    for (int i = 0; i < 4; i++) fetch_chk("t5_w", 32'(4*i), ref_mem[i]);
    fetch_chk("t5_oor", 32'(4*DEPTH), 32'd0);
    for (int r = 0; r < 3; r++) begin
      int n = $urandom_range(1, 6);
      do_start(n);
      rand_q(n);
      send_q(1'b1, 4*n);
      chk_done("rnd");
      commit_q(n);
      for (int i = 0; i < n; i++) fetch_chk("rnd_w", 32'(4*i + $urandom_range(0, 3)), ref_mem[i]);
    end

    // 6. reset mid-load keeps completed word; zero-length start
    do_start(2);
    rand_q(2);
    send_q(1'b0, 5);
    rst = 1'b0;
    step();
    rst = 1'b1;
    commit_q(1);
    chk("t6_busy", 32'(bus.busy_o), 32'd0);
    chk("t6_rdy", 32'(bus.ld_ready_o), 32'd0);
    fetch_chk("t6_w0", 32'd0, ref_mem[0]);
    do_start(0);
    chk("t6_done", 32'(bus.done_o), 32'd1);
    chk("t6_zbusy", 32'(bus.busy_o), 32'd0);
    step();
    chk("t6_done_end", 32'(bus.done_o), 32'd0);
    fetch_chk("t6_w0b", 32'd0, ref_mem[0]);
    fetch_chk("t6_w1", 32'd4, ref_mem[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
